// File: rtl/k_lsu_pkg.sv
// Shared types and helpers for the k_load_store_unit data-memory initiator.
// Holds the FSM encoding, access-size codes and byte-lane arithmetic.
package k_lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
        ST_FIN   = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Bit offset of the addressed lane inside the memory word; words sit at 0.
    function automatic logic [4:0] lane_shift(input logic [1:0] lane,
                                              input logic [1:0] size,
                                              input logic       big_endian);
        logic [4:0] shift;
        shift = 5'd0;
        if (size == SZ_BYTE) begin
            shift = {(big_endian ? ~lane : lane), 3'b000};
        end else if (size == SZ_HALF) begin
            shift = {(big_endian ? ~lane[1] : lane[1]), 4'b0000};
        end
        return shift;
    endfunction

    // Size code 11 behaves as a word, so any size with bit 1 set needs addr[1:0]=0.
    function automatic logic addr_misaligned(input logic [1:0] lane,
                                             input logic [1:0] size);
        return ((size == SZ_HALF) && lane[0]) || (size[1] && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/k_lsu_lane.sv
// Combinational byte/half lane logic: sign/zero-extending extract (MERGE=0)
// or read-modify-write merge of right-justified store data (MERGE=1).
module k_lsu_lane
    import k_lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0,
    parameter bit MERGE      = 1'b0
) (
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [4:0]  shift;
    logic [15:0] aligned;
    logic [31:0] lane_mask;
    logic [31:0] extracted;
    logic [31:0] merged;

    always_comb begin
        shift   = lane_shift(lane, size, BIG_ENDIAN);
        aligned = 16'(word >> shift);
        case (size)
            SZ_BYTE: begin
                lane_mask = 32'h0000_00FF;
                extracted = {{24{~is_unsigned & aligned[7]}}, aligned[7:0]};
            end
            SZ_HALF: begin
                lane_mask = 32'h0000_FFFF;
                extracted = {{16{~is_unsigned & aligned[15]}}, aligned[15:0]};
            end
            default: begin
                lane_mask = 32'hFFFF_FFFF;
                extracted = word;
            end
        endcase
        // Lanes outside the mask come straight from the read word.
        merged = (word & ~(lane_mask << shift)) | ((wdata & lane_mask) << shift);
        result = MERGE ? merged : extracted;
    end

endmodule

// File: rtl/k_load_store_unit.sv
// MEM-stage load/store initiator: word transactions on a req/ack handshake,
// read-modify-write for sub-word stores, alignment and ack-timeout faults.
module k_load_store_unit
    import k_lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN  = 1'b0,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        K_clk,
    input  logic        K_reset,
    input  logic        K_req,
    input  logic        K_is_store,
    input  logic [1:0]  K_size,
    input  logic        K_unsigned,
    input  logic [31:0] K_addr,
    input  logic [31:0] K_wdata,
    output logic [31:0] K_rdata,
    output logic        K_busy,
    output logic        K_done,
    output logic        K_misaligned,
    output logic        K_timeout,
    output logic        K_mem_req,
    output logic        K_mem_we,
    output logic [31:0] K_mem_addr,
    output logic [31:0] K_mem_wdata,
    input  logic [31:0] K_mem_rdata,
    input  logic        K_mem_ack
);

    localparam logic [15:0] CNT_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [1:0]  lane_reg, lane_next;
    logic [1:0]  size_reg, size_next;
    logic        is_store_reg, is_store_next;
    logic        unsigned_reg, unsigned_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] word_reg, word_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        timed_out_reg, timed_out_next;
    logic        mem_req_reg, mem_req_next;
    logic        mem_we_reg, mem_we_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        busy_reg, done_reg, done_next;
    logic        misaligned_reg, misaligned_next;
    logic        timeout_reg, timeout_next;
    logic [31:0] load_value, store_word;
    logic        ack_expired;

    k_lsu_lane #(.BIG_ENDIAN(BIG_ENDIAN), .MERGE(1'b0)) u_extract (
        .word(word_reg), .wdata(wdata_reg), .lane(lane_reg), .size(size_reg),
        .is_unsigned(unsigned_reg), .result(load_value)
    );

    k_lsu_lane #(.BIG_ENDIAN(BIG_ENDIAN), .MERGE(1'b1)) u_merge (
        .word(word_reg), .wdata(wdata_reg), .lane(lane_reg), .size(size_reg),
        .is_unsigned(unsigned_reg), .result(store_word)
    );

    assign ack_expired = (cnt_reg == CNT_LAST);

    always_comb begin
        state_next      = state_reg;
        lane_next       = lane_reg;
        size_next       = size_reg;
        is_store_next   = is_store_reg;
        unsigned_next   = unsigned_reg;
        wdata_next      = wdata_reg;
        word_next       = word_reg;
        cnt_next        = cnt_reg;
        timed_out_next  = timed_out_reg;
        mem_req_next    = mem_req_reg;
        mem_we_next     = mem_we_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        rdata_next      = rdata_reg;
        done_next       = 1'b0;
        misaligned_next = 1'b0;
        timeout_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (K_req) begin
                    lane_next      = K_addr[1:0];
                    size_next      = K_size;
                    is_store_next  = K_is_store;
                    unsigned_next  = K_unsigned;
                    wdata_next     = K_wdata;
                    mem_addr_next  = {K_addr[31:2], 2'b00};
                    cnt_next       = 16'd0;
                    timed_out_next = 1'b0;
                    if (addr_misaligned(K_addr[1:0], K_size)) begin
                        state_next      = ST_FAULT;
                        done_next       = 1'b1;
                        misaligned_next = 1'b1;
                        rdata_next      = 32'd0;
                    end else if (K_is_store && K_size[1]) begin
                        state_next     = ST_WR;
                        mem_req_next   = 1'b1;
                        mem_we_next    = 1'b1;
                        mem_wdata_next = K_wdata;
                    end else begin
                        state_next   = ST_RD;
                        mem_req_next = 1'b1;
                        mem_we_next  = 1'b0;
                    end
                end
            end
            ST_RD: begin
                if (K_mem_ack) begin
                    word_next    = K_mem_rdata;
                    mem_req_next = 1'b0;
                    state_next   = is_store_reg ? ST_WR : ST_FIN;
                end else if (ack_expired) begin
                    mem_req_next   = 1'b0;
                    timed_out_next = 1'b1;
                    state_next     = ST_FIN;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_WR: begin
                // Arriving from RD, req is low for this one cycle while the merge settles.
                if (!mem_req_reg) begin
                    mem_req_next   = 1'b1;
                    mem_we_next    = 1'b1;
                    mem_wdata_next = store_word;
                    cnt_next       = 16'd0;
                end else if (K_mem_ack) begin
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                    state_next   = ST_FIN;
                end else if (ack_expired) begin
                    mem_req_next   = 1'b0;
                    mem_we_next    = 1'b0;
                    timed_out_next = 1'b1;
                    state_next     = ST_FIN;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_FIN: begin
                done_next    = 1'b1;
                timeout_next = timed_out_reg;
                rdata_next   = (is_store_reg || timed_out_reg) ? 32'd0 : load_value;
                state_next   = ST_IDLE;
            end
            ST_FAULT: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge K_clk or posedge K_reset) begin
        if (K_reset) begin
            state_reg      <= ST_IDLE;
            lane_reg       <= 2'd0;
            size_reg       <= 2'd0;
            is_store_reg   <= 1'b0;
            unsigned_reg   <= 1'b0;
            wdata_reg      <= 32'd0;
            word_reg       <= 32'd0;
            cnt_reg        <= 16'd0;
            timed_out_reg  <= 1'b0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= 32'd0;
            mem_wdata_reg  <= 32'd0;
            rdata_reg      <= 32'd0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            misaligned_reg <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lane_reg       <= lane_next;
            size_reg       <= size_next;
            is_store_reg   <= is_store_next;
            unsigned_reg   <= unsigned_next;
            wdata_reg      <= wdata_next;
            word_reg       <= word_next;
            cnt_reg        <= cnt_next;
            timed_out_reg  <= timed_out_next;
            mem_req_reg    <= mem_req_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            rdata_reg      <= rdata_next;
            busy_reg       <= (state_next != ST_IDLE);
            done_reg       <= done_next;
            misaligned_reg <= misaligned_next;
            timeout_reg    <= timeout_next;
        end
    end

    assign K_rdata      = rdata_reg;
    assign K_busy       = busy_reg;
    assign K_done       = done_reg;
    assign K_misaligned = misaligned_reg;
    assign K_timeout    = timeout_reg;
    assign K_mem_req    = mem_req_reg;
    assign K_mem_we     = mem_we_reg;
    assign K_mem_addr   = mem_addr_reg;
    assign K_mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_k_load_store_unit.sv
// Bench for k_load_store_unit: little- and big-endian instances share stimulus
// and memory; a memory-semantics model predicts every transaction and completion.
module tb_k_load_store_unit;
    import k_lsu_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd_le;
        logic [31:0] wd_be;
    } mop_t;

    typedef struct packed {
        logic [31:0] rd_le;
        logic [31:0] rd_be;
        logic        mis;
        logic        tmo;
    } done_t;

    logic        clk, rst, req, is_store, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata, mem_rdata;
    logic        mem_ack;

    logic [31:0] rdata_le, rdata_be, mem_addr_le, mem_addr_be, mem_wdata_le, mem_wdata_be;
    logic        busy_le, busy_be, done_le, done_be, mis_le, mis_be, to_le, to_be;
    logic        mem_req_le, mem_req_be, mem_we_le, mem_we_be;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          req_cycles = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    bit          write_ack_en = 1'b1;
    logic [31:0] mem_word = 32'd0;
    logic [31:0] last_addr = 32'd0;
    logic [31:0] last_wd_le = 32'd0;
    mop_t        exp_mem_q[$];
    done_t       exp_done_q[$];

    k_load_store_unit #(.BIG_ENDIAN(1'b0), .ACK_TIMEOUT(4)) dut_le (
        .K_clk(clk), .K_reset(rst), .K_req(req), .K_is_store(is_store), .K_size(size),
        .K_unsigned(uns), .K_addr(addr), .K_wdata(wdata), .K_rdata(rdata_le),
        .K_busy(busy_le), .K_done(done_le), .K_misaligned(mis_le), .K_timeout(to_le),
        .K_mem_req(mem_req_le), .K_mem_we(mem_we_le), .K_mem_addr(mem_addr_le),
        .K_mem_wdata(mem_wdata_le), .K_mem_rdata(mem_rdata), .K_mem_ack(mem_ack)
    );

    k_load_store_unit #(.BIG_ENDIAN(1'b1), .ACK_TIMEOUT(4)) dut_be (
        .K_clk(clk), .K_reset(rst), .K_req(req), .K_is_store(is_store), .K_size(size),
        .K_unsigned(uns), .K_addr(addr), .K_wdata(wdata), .K_rdata(rdata_be),
        .K_busy(busy_be), .K_done(done_be), .K_misaligned(mis_be), .K_timeout(to_be),
        .K_mem_req(mem_req_be), .K_mem_we(mem_we_be), .K_mem_addr(mem_addr_be),
        .K_mem_wdata(mem_wdata_be), .K_mem_rdata(mem_rdata), .K_mem_ack(mem_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte at memory offset k of the word, in the given byte order.
    function automatic logic [7:0] byte_at(input logic [31:0] w, input int k, input bit be);
        int p;
        p = be ? 3 - k : k;
        return w[8*p +: 8];
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                               input logic [1:0] sz, input bit u, input bit be);
        int off;
        logic [7:0] b;
        logic [15:0] h;
        off = int'(a[1:0]);
        if (sz == SZ_BYTE) begin
            b = byte_at(w, off, be);
            return u ? {24'h0, b} : {{24{b[7]}}, b};
        end
        if (sz == SZ_HALF) begin
            off = off & 2;
            h = be ? {byte_at(w, off, be), byte_at(w, off + 1, be)}
                   : {byte_at(w, off + 1, be), byte_at(w, off, be)};
            return u ? {16'h0, h} : {{16{h[15]}}, h};
        end
        return w;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] a,
                                                input logic [1:0] sz, input logic [31:0] d,
                                                input bit be);
        logic [7:0] b [4];
        int off;
        for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
        off = int'(a[1:0]);
        if (sz == SZ_BYTE) begin
            b[be ? 3 - off : off] = d[7:0];
        end else if (sz == SZ_HALF) begin
            off = off & 2;
            b[be ? 3 - off : off]             = be ? d[15:8] : d[7:0];
            b[be ? 3 - (off + 1) : (off + 1)] = be ? d[7:0]  : d[15:8];
        end else begin
            return d;
        end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    // Memory: acks after ack_delay waiting cycles of req; ack_delay<0 never acks.
    always @(posedge clk) begin
        #1;
        if (mem_req_le && (!mem_we_le || write_ack_en) && ack_delay >= 0 && wait_cnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_word;
            wait_cnt  = 0;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            wait_cnt  = mem_req_le ? wait_cnt + 1 : 0;
        end
    end

    // Compare process: memory transactions and completions against the model queues.
    always @(negedge clk) begin
        mop_t  op;
        done_t dn;
        if (mem_req_le) req_cycles++;
        if (mem_req_le && mem_ack) begin
            if (exp_mem_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_mem_ack: got addr %h we %0d expected no access", mem_addr_le, mem_we_le);
            end else begin
                op = exp_mem_q.pop_front();
                chk("mem_req_be", 32'(mem_req_be), 32'd1);
                chk("mem_addr_le", mem_addr_le, op.addr);
                chk("mem_addr_be", mem_addr_be, op.addr);
                chk("mem_we_le", 32'(mem_we_le), 32'(op.we));
                chk("mem_we_be", 32'(mem_we_be), 32'(op.we));
                if (op.we) begin
                    chk("mem_wdata_le", mem_wdata_le, op.wd_le);
                    chk("mem_wdata_be", mem_wdata_be, op.wd_be);
                    last_wd_le = mem_wdata_le;
                end
                last_addr = mem_addr_le;
            end
        end
        if (done_le || done_be) begin
            if (exp_done_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done %0d/%0d expected 0", done_le, done_be);
            end else begin
                dn = exp_done_q.pop_front();
                chk("done_le", 32'(done_le), 32'd1);
                chk("done_be", 32'(done_be), 32'd1);
                chk("rdata_le", rdata_le, dn.rd_le);
                chk("rdata_be", rdata_be, dn.rd_be);
                chk("misaligned_le", 32'(mis_le), 32'(dn.mis));
                chk("misaligned_be", 32'(mis_be), 32'(dn.mis));
                chk("timeout_le", 32'(to_le), 32'(dn.tmo));
                chk("timeout_be", 32'(to_be), 32'(dn.tmo));
            end
        end else begin
            chk("idle_flags", {28'd0, mis_le, mis_be, to_le, to_be}, 32'd0);
        end
    end

    task automatic run(input bit b2b, input bit st, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] w,
                       input int delay, input int exp_lat, input int exp_reqc,
                       output logic [31:0] rd_le, output logic [31:0] rd_be);
        bit    fault, tmo;
        mop_t  op;
        done_t dn;
        int    lat, reqc0;
        fault = ((sz == SZ_HALF) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
        tmo   = !fault && (delay < 0);
        if (!fault && !tmo) begin
            if (!(st && sz[1])) begin
                op = '{addr: {a[31:2], 2'b00}, we: 1'b0, wd_le: 32'd0, wd_be: 32'd0};
                exp_mem_q.push_back(op);
            end
            if (st) begin
                op = '{addr: {a[31:2], 2'b00}, we: 1'b1,
                       wd_le: model_store(w, a, sz, d, 1'b0), wd_be: model_store(w, a, sz, d, 1'b1)};
                exp_mem_q.push_back(op);
            end
        end
        dn.rd_le = (st || fault || tmo) ? 32'd0 : model_load(w, a, sz, u, 1'b0);
        dn.rd_be = (st || fault || tmo) ? 32'd0 : model_load(w, a, sz, u, 1'b1);
        dn.mis   = fault;
        dn.tmo   = tmo;
        exp_done_q.push_back(dn);
        mem_word  = w;
        ack_delay = delay;
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        req = 1'b1; is_store = st; size = sz; uns = u; addr = a; wdata = d;
        reqc0 = req_cycles;
        @(posedge clk);
        #1;
        req = 1'b0; is_store = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        lat = 1;
        while (!done_le && lat < 40) begin
            chk("busy_wait", 32'(busy_le), 32'd1);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("busy_at_done", 32'(busy_le), 32'(fault));
        chk("req_cycles", req_cycles - reqc0, exp_reqc);
        rd_le = rdata_le;
        rd_be = rdata_be;
        $display("txn st=%0d sz=%0d u=%0d addr=%h wd=%h word=%h lat=%0d rd_le=%h rd_be=%h",
                 st, sz, u, a, d, w, lat, rd_le, rd_be);
    endtask

    initial begin
        logic [31:0] rl, rb;
        int lat;
        rst = 1'b1; req = 1'b0; is_store = 1'b0; size = 2'd0; uns = 1'b0;
        addr = 32'd0; wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs_le", {rdata_le | mem_addr_le | mem_wdata_le},  32'd0);
        chk("reset_outs_be", {rdata_be | mem_addr_be | mem_wdata_be},  32'd0);
        chk("reset_flags", {24'd0, busy_le, done_le, mis_le, to_le, mem_req_le, mem_we_le, busy_be, done_be}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 2, 5, 3, rl, rb);
        chk("lw_rdata_lit", rl, 32'hDEADBEEF);
        chk("lw_addr_lit", last_addr, 32'h10);
        chk("lw_busy_after", 32'(busy_le), 32'd0);
        run(0, 0, SZ_BYTE, 0, 32'h13, 32'h0, 32'h80FF1234, 0, 3, 1, rl, rb);
        chk("lb_le_lit", rl, 32'hFFFFFF80);
        chk("lb_be_lit", rb, 32'h00000034);
        run(1, 0, SZ_BYTE, 1, 32'h13, 32'h0, 32'h80FF1234, 0, 3, 1, rl, rb);
        chk("lbu_le_lit", rl, 32'h00000080);
        run(0, 1, SZ_HALF, 0, 32'h22, 32'hAAAA5678, 32'h11223344, 0, 5, 2, rl, rb);
        chk("sh_wdata_lit", last_wd_le, 32'h56783344);
        chk("sh_addr_lit", last_addr, 32'h20);
        run(0, 0, SZ_HALF, 0, 32'h05, 32'h0, 32'h12345678, 0, 1, 0, rl, rb);
        run(0, 1, SZ_WORD, 0, 32'h30, 32'h01020304, 32'h0, -1, 6, 4, rl, rb);
        chk("sw_tmo_idle", 32'(busy_le), 32'd0);
        run(0, 0, SZ_HALF, 0, 32'h16, 32'h0, 32'h80017FFE, 1, 4, 2, rl, rb);
        run(1, 1, SZ_BYTE, 0, 32'h09, 32'h123456C3, 32'hA5A5A5A5, 0, 5, 2, rl, rb);
        chk("sb_wdata_lit", last_wd_le, 32'hA5A5C3A5);
        run(0, 0, SZ_WORD, 0, 32'h12, 32'h0, 32'h0, 0, 1, 0, rl, rb);
        run(0, 1, SZ_WORD, 0, 32'h31, 32'h5, 32'h0, 0, 1, 0, rl, rb);
        run(0, 0, SZ_HALF, 1, 32'h0A, 32'h0, 32'hF00DBEEF, 3, 6, 4, rl, rb);
        chk("lhu_le_lit", rl, 32'h0000F00D);
        chk("lhu_be_lit", rb, 32'h0000BEEF);
        run(0, 1, SZ_BYTE, 0, 32'h43, 32'h99, 32'h0, -1, 6, 4, rl, rb);
        run(1, 0, 2'b11, 0, 32'h1C, 32'h0, 32'h13579BDF, 0, 3, 1, rl, rb);
        run(1, 1, SZ_WORD, 0, 32'h24, 32'hCAFEF00D, 32'h0, 1, 4, 2, rl, rb);
        chk("sw_rdata_zero", rl, 32'd0);

        // Reset while the write half of an sb is outstanding.
        write_ack_en = 1'b0;
        ack_delay    = 0;
        mem_word     = 32'h0BADF00D;
        exp_mem_q.push_back('{addr: 32'h40, we: 1'b0, wd_le: 32'd0, wd_be: 32'd0});
        @(posedge clk);
        #1;
        req = 1'b1; is_store = 1'b1; size = SZ_BYTE; uns = 1'b0; addr = 32'h41; wdata = 32'h77;
        @(posedge clk);
        #1;
        req = 1'b0;
        lat = 0;
        while (!(mem_req_le && mem_we_le) && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("rst_reached_wr", 32'(mem_req_le && mem_we_le), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_req_drop", {28'd0, mem_req_le, mem_req_be, busy_le, done_le}, 32'd0);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("rst_no_done", {30'd0, done_le, done_be}, 32'd0);
        end
        write_ack_en = 1'b1;
        $display("txn reset during sb write");
        run(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'h2468ACE1, 0, 3, 1, rl, rb);
        chk("lw_after_rst_lit", rl, 32'h2468ACE1);

        repeat (3) @(posedge clk);
        #1;
        chk("mem_q_left", exp_mem_q.size(), 32'd0);
        chk("done_q_left", exp_done_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 expected finish");
        $fatal(1, "watchdog");
    end

endmodule
